// File: rtl/ddr5_dev_responder.sv
// ddr5_dev_responder: device-side DDR5 CS_n/CA decoder with a small burst store.
// Optional macro DDR5_RSP_TIMING_CHK_EN adds per-bank T_ACT/T_PRE checking.
module ddr5_dev_responder #(
    parameter int CL       = 20,
    parameter int CWL      = 20,
    parameter int BL       = 2,
    parameter int T_ACT    = 5,
    parameter int T_PRE    = 5,
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 4
) (
    input  logic        mem_clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic [13:0] ca,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        err_illegal,
    output logic        err_collision,
    output logic        err_timing
);
    localparam int AW = 4 + ROW_BITS + COL_BITS;
    localparam int BW = (BL > 1) ? $clog2(BL) : 1;
    localparam logic [BW-1:0] LAST = BW'(BL - 1);

    typedef enum logic {S_IDLE, S_CMD2} state_t;
    typedef enum logic [1:0] {C_ACT, C_RD, C_WR} cmd_t;

    state_t              state_q;
    cmd_t                pcmd_q;
    logic [3:0]          pbank_q;
    logic [15:0]         open_q;
    logic [ROW_BITS-1:0] row_q [16];
    logic [CL-2:0]       rv_q;
    logic [AW-1:0]       ra_q [CL-1];
    logic [CWL-2:0]      wv_q;
    logic [AW-1:0]       wa_q [CWL-1];
    logic                rd_act_q, wr_act_q;
    logic [BW-1:0]       rd_beat_q, wr_beat_q;
    logic [AW-1:0]       rd_base_q, wr_base_q;
    logic                ill_q, coll_q;
    logic [15:0]         mem_q [2**AW];

    logic [3:0]    bank;
    logic          is_act, is_rd, is_wr, is_pre, is_nop;
    logic          cmd_ok, pre_v, fin, act_fin, rd_push, wr_push, ill_d;
    cmd_t          cmd_d;
    logic [AW-1:0] push_a, rd_addr, wr_addr;
    logic          rd_busy, rd_go, rd_act_d, wr_busy, wr_go, wr_act_d, coll_d;

    // Command decode, bank-state legality and burst scheduling decisions
    always_comb begin
        bank   = {ca[7:5], ca[8]};
        is_act = (ca[1:0] == 2'b00);
        is_wr  = (ca[4:0] == 5'b01101);
        is_rd  = (ca[4:0] == 5'b11101);
        is_pre = (ca[4:0] == 5'b11011);
        is_nop = (ca[4:0] == 5'b11111);
        cmd_ok = 1'b0;
        cmd_d  = C_ACT;
        pre_v  = 1'b0;
        ill_d  = !cs_n && (state_q == S_CMD2);
        if (!cs_n) begin
            unique case (1'b1)
                is_act: begin
                    cmd_ok = !open_q[bank];
                    ill_d  = ill_d | open_q[bank];
                end
                is_rd, is_wr: begin
                    cmd_ok = open_q[bank];
                    cmd_d  = is_rd ? C_RD : C_WR;
                    ill_d  = ill_d | !open_q[bank];
                end
                is_pre:  pre_v = 1'b1;
                is_nop:  cmd_ok = 1'b0;
                default: ill_d = 1'b1;
            endcase
        end
        fin      = cs_n && (state_q == S_CMD2);
        act_fin  = fin && (pcmd_q == C_ACT);
        rd_push  = fin && (pcmd_q == C_RD);
        wr_push  = fin && (pcmd_q == C_WR);
        push_a   = {pbank_q, row_q[pbank_q], ca[COL_BITS-1:0]};
        rd_busy  = rd_act_q && (rd_beat_q != LAST);
        rd_go    = rv_q[CL-2] && !rd_busy;
        rd_act_d = rd_busy || rd_go;
        wr_busy  = wr_act_q && (wr_beat_q != LAST);
        wr_go    = wv_q[CWL-2] && !wr_busy;
        wr_act_d = wr_busy || wr_go;
        coll_d   = (rv_q[CL-2] && rd_busy) || (wv_q[CWL-2] && wr_busy)
                   || (rd_act_d && wr_act_d);
    end

    // Command FSM, bank table, latency delay lines and burst engines
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pcmd_q    <= C_ACT;
            pbank_q   <= '0;
            open_q    <= '0;
            rv_q      <= '0;
            wv_q      <= '0;
            rd_act_q  <= 1'b0;
            wr_act_q  <= 1'b0;
            rd_beat_q <= '0;
            wr_beat_q <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            ill_q     <= 1'b0;
            coll_q    <= 1'b0;
            for (int i = 0; i < 16; i++) row_q[i] <= '0;
            for (int i = 0; i < CL - 1; i++) ra_q[i] <= '0;
            for (int i = 0; i < CWL - 1; i++) wa_q[i] <= '0;
        end else begin
            ill_q   <= ill_d;
            coll_q  <= coll_d;
            state_q <= cmd_ok ? S_CMD2 : S_IDLE;
            if (cmd_ok) begin
                pcmd_q  <= cmd_d;
                pbank_q <= bank;
            end
            if (pre_v) open_q[bank] <= 1'b0;
            if (act_fin) begin
                open_q[pbank_q] <= 1'b1;
                row_q[pbank_q]  <= ca[ROW_BITS-1:0];
            end
            rv_q[0] <= rd_push;
            ra_q[0] <= push_a;
            for (int i = 1; i < CL - 1; i++) begin
                rv_q[i] <= rv_q[i-1];
                ra_q[i] <= ra_q[i-1];
            end
            wv_q[0] <= wr_push;
            wa_q[0] <= push_a;
            for (int i = 1; i < CWL - 1; i++) begin
                wv_q[i] <= wv_q[i-1];
                wa_q[i] <= wa_q[i-1];
            end
            rd_act_q <= rd_act_d;
            if (rd_go) begin
                rd_base_q <= ra_q[CL-2];
                rd_beat_q <= '0;
            end else if (rd_busy) begin
                rd_beat_q <= rd_beat_q + BW'(1);
            end
            wr_act_q <= wr_act_d;
            if (wr_go) begin
                wr_base_q <= wa_q[CWL-2];
                wr_beat_q <= '0;
            end else if (wr_busy) begin
                wr_beat_q <= wr_beat_q + BW'(1);
            end
        end
    end

    assign rd_addr = {rd_base_q[AW-1:COL_BITS],
                      rd_base_q[COL_BITS-1:0] + COL_BITS'(rd_beat_q)};
    assign wr_addr = {wr_base_q[AW-1:COL_BITS],
                      wr_base_q[COL_BITS-1:0] + COL_BITS'(wr_beat_q)};

    // Write beats land at the edge closing their cycle; reads see prior contents
    always_ff @(posedge mem_clk) begin
        if (wr_act_q) mem_q[wr_addr] <= dq_in;
    end

    assign dq_oe         = rd_act_q;
    assign dq_out        = rd_act_q ? mem_q[rd_addr] : 16'h0000;
    assign err_illegal   = ill_q;
    assign err_collision = coll_q;

    logic unused_ca;
    assign unused_ca = ^ca;

`ifdef DDR5_RSP_TIMING_CHK_EN
    localparam int AC = $clog2(T_ACT + 1);
    localparam int PC = $clog2(T_PRE + 1);
    logic [AC-1:0] act_cnt_q [16];
    logic [PC-1:0] pre_cnt_q [16];
    logic          tim_d, tim_q;

    // Flag ACT too soon after PRE, and RD/WR too soon after ACT
    always_comb begin
        tim_d = 1'b0;
        if (!cs_n && is_act && !open_q[bank] && (pre_cnt_q[bank] < PC'(T_PRE)))
            tim_d = 1'b1;
        if (fin && (pcmd_q != C_ACT) && (act_cnt_q[pbank_q] < AC'(T_ACT)))
            tim_d = 1'b1;
    end

    // Saturating per-bank cycles-since-event counters
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            tim_q <= 1'b0;
            for (int b = 0; b < 16; b++) begin
                act_cnt_q[b] <= AC'(T_ACT);
                pre_cnt_q[b] <= PC'(T_PRE);
            end
        end else begin
            tim_q <= tim_d;
            for (int b = 0; b < 16; b++) begin
                if (act_fin && (pbank_q == 4'(b)))
                    act_cnt_q[b] <= AC'(1);
                else if (act_cnt_q[b] < AC'(T_ACT))
                    act_cnt_q[b] <= act_cnt_q[b] + AC'(1);
                if (pre_v && (bank == 4'(b)))
                    pre_cnt_q[b] <= PC'(1);
                else if (pre_cnt_q[b] < PC'(T_PRE))
                    pre_cnt_q[b] <= pre_cnt_q[b] + PC'(1);
            end
        end
    end

    assign err_timing = tim_q;
`else
    logic [31:0] unused_tchk;
    assign unused_tchk = T_ACT + T_PRE;
    assign err_timing  = 1'b0;
`endif
endmodule

// File: tb/tb_ddr5_dev_responder.sv
// tb_ddr5_dev_responder: scoreboard bench with a cycle-schedule reference model.
// Expectations are booked per absolute cycle; a negedge monitor pops and compares.
module tb_ddr5_dev_responder;
    localparam int CL    = 20;
    localparam int CWL   = 20;
    localparam int BL    = 2;
    localparam int T_ACT = 5;
    localparam int T_PRE = 5;
    localparam logic [4:0] OP_ACT = 5'b00000;
    localparam logic [4:0] OP_WR  = 5'b01101;
    localparam logic [4:0] OP_RD  = 5'b11101;
    localparam logic [4:0] OP_PRE = 5'b11011;
    localparam logic [4:0] OP_NOP = 5'b11111;

    logic        mem_clk = 1'b0;
    logic        rst_n   = 1'b1;
    logic        cs_n    = 1'b1;
    logic [13:0] ca      = '0;
    logic [15:0] dq_in   = '0;
    logic [15:0] dq_out;
    logic        dq_oe, err_illegal, err_collision, err_timing;

    ddr5_dev_responder dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .cs_n(cs_n), .ca(ca),
        .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
        .err_illegal(err_illegal), .err_collision(err_collision),
        .err_timing(err_timing)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct {int c; int a;} beat_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    beat_t       rdq[$];
    int          illq[$];
    int          timq[$];
    bit          coll_set[int];
    int          rd_book[int];
    int          wr_book[int];
    logic [15:0] tb_mem[1024];
    bit          tb_val[1024];
    bit          bopen[16];
    int          brow[16];
    int          last_act[16];
    int          last_pre[16];
    bit          pend = 1'b0;
    int          pkind, pbank;
    logic [15:0] wdata_q[$];
    bit          wc_v = 1'b0;
    int          wc_a;
    logic [15:0] wc_d;
    beat_t       mon_b;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    function automatic void exp_ill(input int c);
        if (illq.size() == 0 || illq[$] != c) illq.push_back(c);
    endfunction

    function automatic void exp_tim(input int c);
        if (timq.size() == 0 || timq[$] != c) timq.push_back(c);
    endfunction

    function automatic void model_reset();
        rdq.delete(); illq.delete(); timq.delete();
        coll_set.delete(); rd_book.delete(); wr_book.delete();
        pend = 1'b0;
        wc_v = 1'b0;
        for (int b = 0; b < 16; b++) begin
            bopen[b] = 1'b0;
            last_act[b] = -1000;
            last_pre[b] = -1000;
        end
    endfunction

    // Reserve beat cycles for a burst; overlaps become collision cycles
    function automatic void book(input bit is_rd, input int t, input int hi, input int col);
        int s = t + (is_rd ? CL : CWL);
        if (is_rd ? rd_book.exists(s) : wr_book.exists(s)) begin
            coll_set[s] = 1'b1;
            return;
        end
        for (int k = 0; k < BL; k++) begin
            int a = hi + ((col + k) % 16);
            if (is_rd) begin
                rd_book[s+k] = a;
                rdq.push_back('{s + k, a});
                if (wr_book.exists(s + k)) coll_set[s+k] = 1'b1;
            end else begin
                wr_book[s+k] = a;
                if (rd_book.exists(s + k)) coll_set[s+k] = 1'b1;
            end
        end
    endfunction

    function automatic void model_cycle(input logic csn, input logic [13:0] c);
        int b = int'({c[7:5], c[8]});
        if (!csn) begin
            if (pend) begin
                exp_ill(cyc + 1);
                pend = 1'b0;
            end
            if (c[1:0] == 2'b00) begin
                if (bopen[b]) exp_ill(cyc + 1);
                else begin
`ifdef DDR5_RSP_TIMING_CHK_EN
                    if (cyc - last_pre[b] < T_PRE) exp_tim(cyc + 1);
`endif
                    pend = 1'b1; pkind = 0; pbank = b;
                end
            end else if (c[4:0] == OP_RD || c[4:0] == OP_WR) begin
                if (!bopen[b]) exp_ill(cyc + 1);
                else begin
                    pend = 1'b1; pkind = (c[4:0] == OP_RD) ? 1 : 2; pbank = b;
                end
            end else if (c[4:0] == OP_PRE) begin
                bopen[b] = 1'b0;
                last_pre[b] = cyc;
            end else if (c[4:0] != OP_NOP) begin
                exp_ill(cyc + 1);
            end
        end else if (pend) begin
            pend = 1'b0;
            if (pkind == 0) begin
                bopen[pbank] = 1'b1;
                brow[pbank] = int'(c[1:0]);
                last_act[pbank] = cyc;
            end else begin
`ifdef DDR5_RSP_TIMING_CHK_EN
                if (cyc - last_act[pbank] < T_ACT) exp_tim(cyc + 1);
`endif
                book(pkind == 1, cyc, pbank * 64 + brow[pbank] * 16, int'(c[3:0]));
            end
        end
    endfunction

    task automatic step(input logic csn, input logic [13:0] c);
        @(posedge mem_clk);
        cyc++;
        if (wc_v) begin
            tb_mem[wc_a] = wc_d;
            tb_val[wc_a] = 1'b1;
            wc_v = 1'b0;
        end
        #1;
        cs_n  = csn;
        ca    = c;
        dq_in = 16'($urandom);
        if (rst_n) begin
            if (wr_book.exists(cyc)) begin
                if (wdata_q.size() > 0) dq_in = wdata_q.pop_front();
                wc_v = 1'b1;
                wc_a = wr_book[cyc];
                wc_d = dq_in;
            end
            model_cycle(csn, c);
        end
    endtask

    function automatic logic [13:0] c1(input logic [4:0] op, input int b);
        logic [3:0] bb = b[3:0];
        return {5'b00000, bb[0], bb[3:1], op};
    endfunction

    task automatic idle(input int n);
        repeat (n) step(1'b1, 14'h0);
    endtask

    task automatic cmd2(input logic [4:0] op, input int b, input logic [13:0] arg);
        step(1'b0, c1(op, b));
        step(1'b1, arg);
    endtask

    function automatic logic [13:0] rand_cmd();
        int r = $urandom_range(0, 99);
        int b = $urandom_range(0, 3);
        logic [4:0] op;
        if (r < 25)      op = OP_ACT;
        else if (r < 45) op = OP_RD;
        else if (r < 65) op = OP_WR;
        else if (r < 80) op = OP_PRE;
        else if (r < 90) op = OP_NOP;
        else if (r < 95) op = 5'b00001;
        else             op = 5'b10101;
        return c1(op, b);
    endfunction

    // Scoreboard monitor: compare every cycle against booked expectations
    always @(negedge mem_clk) begin
        if (!rst_n) begin
            chk("rst_oe", {31'b0, dq_oe}, 32'd0);
            chk("rst_dq", {16'b0, dq_out}, 32'd0);
            chk("rst_err", {29'b0, err_illegal, err_collision, err_timing}, 32'd0);
        end else begin
            if (rdq.size() > 0 && rdq[0].c == cyc) begin
                mon_b = rdq.pop_front();
                chk("rd_oe", {31'b0, dq_oe}, 32'd1);
                if (tb_val[mon_b.a])
                    chk("rd_data", {16'b0, dq_out}, {16'b0, tb_mem[mon_b.a]});
            end else begin
                chk("idle_oe", {31'b0, dq_oe}, 32'd0);
                chk("idle_dq", {16'b0, dq_out}, 32'd0);
            end
            if (illq.size() > 0 && illq[0] == cyc) begin
                void'(illq.pop_front());
                chk("err_illegal", {31'b0, err_illegal}, 32'd1);
            end else begin
                chk("no_illegal", {31'b0, err_illegal}, 32'd0);
            end
            if (timq.size() > 0 && timq[0] == cyc) begin
                void'(timq.pop_front());
                chk("err_timing", {31'b0, err_timing}, 32'd1);
            end else begin
                chk("no_timing", {31'b0, err_timing}, 32'd0);
            end
            chk("err_collision", {31'b0, err_collision},
                {31'b0, coll_set.exists(cyc)});
            if (coll_set.exists(cyc)) coll_set.delete(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) tb_val[i] = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        idle(3);
        @(posedge mem_clk); cyc++; #1; rst_n = 1'b1;

        act(3, 14'h0001);
        idle(5);
        wdata_q.push_back(16'hAAAA); wdata_q.push_back(16'h5555);
        cmd2(OP_WR, 3, 14'h004);
        idle(25);
        cmd2(OP_RD, 3, 14'h004);
        idle(25);

        wdata_q.push_back(16'h1111); wdata_q.push_back(16'h2222);
        cmd2(OP_WR, 3, 14'h00F);
        idle(25);
        cmd2(OP_RD, 3, 14'h000);
        cmd2(OP_RD, 3, 14'h00F);
        idle(25);

        cmd2(OP_RD, 5, 14'h000);
        act(2, 14'h0000);
        act(2, 14'h0001);
        idle(25);

        step(1'b0, c1(OP_RD, 3));
        cmd2(OP_RD, 3, 14'h004);
        idle(25);

        act(6, 14'h0000);
        cmd2(OP_RD, 6, 14'h001);
        step(1'b0, c1(OP_PRE, 6));
        act(6, 14'h0002);
        idle(25);

        cmd2(OP_RD, 3, 14'h004);
        idle(CL - 1);
        @(posedge mem_clk); cyc++; #1;
        rst_n = 1'b0;
        model_reset();
        cs_n = 1'b1;
        #1 chk("rst_abort_oe", {31'b0, dq_oe}, 32'd0);
        idle(2);
        @(posedge mem_clk); cyc++; #1; rst_n = 1'b1;
        idle(3);
        cmd2(OP_RD, 3, 14'h004);
        idle(25);

        repeat (1500) begin
            int r = $urandom_range(0, 99);
            if (pend) begin
                if (r < 85) step(1'b1, 14'($urandom));
                else        step(1'b0, rand_cmd());
            end else begin
                if (r < 55) step(1'b1, 14'($urandom));
                else        step(1'b0, rand_cmd());
            end
        end

        idle(CL + BL + 5);
        @(negedge mem_clk);
        chk("drain_rd", rdq.size(), 32'd0);
        chk("drain_ill", illq.size(), 32'd0);
        chk("drain_tim", timq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic act(input int b, input logic [13:0] row);
        cmd2(OP_ACT, b, row);
    endtask
endmodule
